uart_frame_scheduler: RTL

- Sequences the telemetry UART sender: decides when a 12-byte status frame is launched and issues its one-cycle start pulse.
- Holds a coherent snapshot of all frame fields while the frame drains.
- Launches frames on a periodic timer, and immediately (after a minimum gap) on a new pedestrian or vehicle violation.
- Sits between the vision/traffic-light logic and the sender; drives the sender's start and data-field inputs.

---
 rtl/uart_frame_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_scheduler.sv
// Purpose: decides when the telemetry UART sender launches a status frame and holds its field snapshot.
// Latency: a pending trigger seen in IDLE at edge N captures the snapshot at N and raises start for the cycle after N.
// Backpressure: frames are paced by tx_byte_done pulses from the sender; a watchdog abandons a stalled frame.
//
// Ports:
//   clk, reset             system clock, asynchronous active-high reset
//   enable                 scheduler enable (clears pending triggers when low)
//   *_in                   live bounding box, light countdowns and status levels
//   tx_byte_done           one-cycle pulse per byte sent by the sender
//   start                  one-cycle frame launch pulse
//   x_min..amount          snapshot fields, stable while busy
//   busy                   high from LAUNCH through the end of GAP
//   frame_count            completed frames (wrapping)
//   timeout_err / err_clr  sticky watchdog flag and its clear
module uart_frame_scheduler #(
    parameter int PERIOD_CYCLES  = 10_000_000,
    parameter int GAP_CYCLES     = 1000,
    parameter int FRAME_BYTES    = 12,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] x_min_in,
    input  logic [9:0] x_max_in,
    input  logic [9:0] y_min_in,
    input  logic [9:0] y_max_in,
    input  logic [4:0] red_left_in,
    input  logic [4:0] green_left_in,
    input  logic       light_in,
    input  logic       human_vio_in,
    input  logic       car_vio_in,
    input  logic       amount_in,
    input  logic       tx_byte_done,
    input  logic       err_clr,
    output logic       start,
    output logic [9:0] x_min,
    output logic [9:0] x_max,
    output logic [9:0] y_min,
    output logic [9:0] y_max,
    output logic [4:0] red_left,
    output logic [4:0] green_left,
    output logic       light,
    output logic       human_vio,
    output logic       car_vio,
    output logic       amount,
    output logic       busy,
    output logic [15:0] frame_count,
    output logic       timeout_err
);

    localparam int TMR_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam int BYTE_W = $clog2(FRAME_BYTES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t            state_q;
    logic [TMR_W-1:0]  timer_q;
    logic [WD_W-1:0]   wd_q;
    logic [BYTE_W-1:0] byte_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              pend_per_q;
    logic              pend_evt_q;
    logic              human_prev_q;
    logic              car_prev_q;
    logic              start_q;
    logic              busy_q;
    logic [15:0]       frame_count_q;
    logic              timeout_err_q;
    logic [9:0]        x_min_q, x_max_q, y_min_q, y_max_q;
    logic [4:0]        red_left_q, green_left_q;
    logic              light_q, human_vio_q, car_vio_q, amount_q;

    logic per_set;
    logic evt_set;
    logic capture;
    logic frame_done;
    logic wd_expire;

    assign per_set    = enable && (timer_q == TMR_W'(PERIOD_CYCLES - 1));
    // Simultaneous edges on both violation lines collapse into one pending frame.
    assign evt_set    = enable && ((human_vio_in && !human_prev_q) || (car_vio_in && !car_prev_q));
    assign capture    = (state_q == S_IDLE) && enable && (pend_per_q || pend_evt_q);
    assign frame_done = (state_q == S_WAIT_DONE) && tx_byte_done &&
                        (byte_cnt_q == BYTE_W'(FRAME_BYTES - 1));
    // A frame completing on the watchdog's last cycle counts as completed, not timed out.
    assign wd_expire  = (state_q == S_WAIT_DONE) && !frame_done &&
                        (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            wd_q          <= '0;
            byte_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            pend_per_q    <= 1'b0;
            pend_evt_q    <= 1'b0;
            human_prev_q  <= 1'b0;
            car_prev_q    <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
            x_min_q       <= '0;
            x_max_q       <= '0;
            y_min_q       <= '0;
            y_max_q       <= '0;
            red_left_q    <= '0;
            green_left_q  <= '0;
            light_q       <= 1'b0;
            human_vio_q   <= 1'b0;
            car_vio_q     <= 1'b0;
            amount_q      <= 1'b0;
        end else begin
            // Period timer free-runs regardless of frame activity so the cadence stays fixed.
            if (!enable || per_set) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end

            human_prev_q <= human_vio_in;
            car_prev_q   <= car_vio_in;

            // Set-dominant: a trigger coinciding with capture is kept for the following frame.
            if (!enable) begin
                pend_per_q <= 1'b0;
                pend_evt_q <= 1'b0;
            end else begin
                pend_per_q <= per_set || (pend_per_q && !capture);
                pend_evt_q <= evt_set || (pend_evt_q && !capture);
            end

            if (wd_expire) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    start_q <= 1'b0;
                    if (capture) begin
                        x_min_q      <= x_min_in;
                        x_max_q      <= x_max_in;
                        y_min_q      <= y_min_in;
                        y_max_q      <= y_max_in;
                        red_left_q   <= red_left_in;
                        green_left_q <= green_left_in;
                        light_q      <= light_in;
                        human_vio_q  <= human_vio_in;
                        car_vio_q    <= car_vio_in;
                        amount_q     <= amount_in;
                        start_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    start_q    <= 1'b0;
                    byte_cnt_q <= '0;
                    wd_q       <= '0;
                    state_q    <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    wd_q <= wd_q + 1'b1;
                    if (tx_byte_done) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                    if (frame_done) begin
                        frame_count_q <= frame_count_q + 16'd1;
                        gap_cnt_q     <= '0;
                        state_q       <= S_GAP;
                    end else if (wd_expire) begin
                        gap_cnt_q <= '0;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign start       = start_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;
    assign timeout_err = timeout_err_q;
    assign x_min       = x_min_q;
    assign x_max       = x_max_q;
    assign y_min       = y_min_q;
    assign y_max       = y_max_q;
    assign red_left    = red_left_q;
    assign green_left  = green_left_q;
    assign light       = light_q;
    assign human_vio   = human_vio_q;
    assign car_vio     = car_vio_q;
    assign amount      = amount_q;

endmodule
